// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch unit: single-outstanding sequential word reads feeding a
// PC-tagged prefetch FIFO, with redirect/flush, optional byte swap and sticky fault.
module fetch_prefetch_unit #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     little_endian_en,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_read,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ready,
  input  logic                     mem_error,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_W-1:0]        instr_data,
  output logic [ADDR_W-1:0]        instr_pc,
  output logic                     fault,
  output logic [ADDR_W-1:0]        fault_pc,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int                NB         = DATA_W / 8;
  localparam int                PTR_W      = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(NB);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(NB - 1);
  localparam logic [PTR_W+1:0]  DEPTH_L    = (PTR_W + 2)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, FAULT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, pc_nxt, addr_nxt, fault_pc_nxt, redirect_aligned;
  logic              fault_nxt;

  // Byte reversal, applied on the response cycle only
  logic [DATA_W-1:0] rdata_rev, rdata_sw;
  for (genvar b = 0; b < NB; b++) begin : g_swap
    assign rdata_rev[8*b +: 8] = mem_rdata[8*(NB-1-b) +: 8];
  end
  assign rdata_sw = little_endian_en ? rdata_rev : mem_rdata;

  assign redirect_aligned = redirect_pc & ALIGN_MASK;

  // Prefetch FIFO; pointers carry an extra wrap bit so level = wr - rd
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic [PTR_W+1:0]  lvl_ext, lvl_nxt;
  logic              push, pop, full;

  assign level       = wr_ptr - rd_ptr;
  assign lvl_ext     = {1'b0, level};
  assign full        = (lvl_ext == DEPTH_L);
  assign instr_valid = (level != '0);
  assign instr_data  = q_data[rd_ptr[PTR_W-1:0]];
  assign instr_pc    = q_pc[rd_ptr[PTR_W-1:0]];

  // A flush in the same cycle suppresses both the response and the pop
  assign push    = (state == REQ) && mem_ready && !mem_error && !redirect_valid;
  assign pop     = instr_valid && instr_ready && !redirect_valid;
  assign lvl_nxt = lvl_ext + (PTR_W + 2)'(push) - (PTR_W + 2)'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr[PTR_W-1:0]] <= rdata_sw;
      q_pc[wr_ptr[PTR_W-1:0]]   <= fetch_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = fetch_pc;
    addr_nxt     = mem_addr;
    fault_nxt    = fault;
    fault_pc_nxt = fault_pc;
    case (state)
      IDLE: begin
        if (!redirect_valid && en && !full) begin
          state_nxt = REQ;
          addr_nxt  = fetch_pc;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          // an in-flight read cannot be cancelled; wait it out in DRAIN
          state_nxt = mem_ready ? IDLE : DRAIN;
        end else if (mem_ready && mem_error) begin
          fault_nxt    = 1'b1;
          fault_pc_nxt = mem_addr;
          state_nxt    = FAULT;
        end else if (mem_ready) begin
          pc_nxt = fetch_pc + PC_INC;
          if (en && (lvl_nxt < DEPTH_L)) addr_nxt = fetch_pc + PC_INC;
          else                           state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (mem_ready) state_nxt = IDLE;
      end
      FAULT: begin
        if (redirect_valid) begin
          state_nxt = IDLE;
          fault_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid) pc_nxt = redirect_aligned;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_addr <= RESET_PC;
      mem_read <= 1'b0;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= pc_nxt;
      mem_addr <= addr_nxt;
      mem_read <= (state_nxt == REQ) || (state_nxt == DRAIN);
      fault    <= fault_nxt;
      fault_pc <= fault_pc_nxt;
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule
